// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: destination-tag pipeline driving load-use stall, redirect flush and EX forward selects.
// Build option PIPE_FWD_EN: when defined, forwarding is enabled; when undefined, every in-flight dependency stalls.
module pipe_hazard_ctl #(
  parameter int RA_W     = 5,
  parameter int NPOST    = 3,
  parameter int RESOLVE  = 2,
  parameter int LOAD_RDY = 3,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(NPOST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [RA_W-1:0]  id_wr_reg,
  input  logic             id_is_load,
  input  logic             redirect,
  output logic             stall,
  output logic             flush,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Tag entry k describes the instruction currently in post-ID stage k (1 = EX).
  logic [NPOST:1]   vld_q, vld_d;
  logic [NPOST:1]   wen_q, wen_d;
  logic [NPOST:1]   ld_q, ld_d;
  logic [RA_W-1:0]  wreg_q [1:NPOST];
  logic [RA_W-1:0]  wreg_d [1:NPOST];
  logic [RA_W-1:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic             ex_urs_q, ex_urs_d, ex_urt_q, ex_urt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic             hazard_s;
  logic             stall_s;
  logic             flush_s;
  logic             take_s;
  logic [SEL_W-1:0] fwd_a_s, fwd_b_s;

  function automatic logic match_f(
    input logic            vld,
    input logic            wen,
    input logic [RA_W-1:0] wreg,
    input logic [RA_W-1:0] src,
    input logic            use_src
  );
    return vld & wen & use_src & (wreg == src) & (src != {RA_W{1'b0}});
  endfunction

  assign flush_s = redirect;
  assign take_s  = id_valid & ~stall_s & ~flush_s;

  // ID-stage dependency check against older in-flight producers.
  always_comb begin
    hazard_s = 1'b0;
`ifdef PIPE_FWD_EN
    for (int k = 1; k <= LOAD_RDY - 2; k++) begin
      if (ld_q[k] && (match_f(vld_q[k], wen_q[k], wreg_q[k], id_rs, id_use_rs) ||
                      match_f(vld_q[k], wen_q[k], wreg_q[k], id_rt, id_use_rt))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
`else
    for (int k = 1; k <= NPOST - 1; k++) begin
      if (match_f(vld_q[k], wen_q[k], wreg_q[k], id_rs, id_use_rs) ||
          match_f(vld_q[k], wen_q[k], wreg_q[k], id_rt, id_use_rt)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
`endif
    stall_s = id_valid & ~flush_s & hazard_s;
  end

  // EX operand selects; walking from the oldest stage down leaves the youngest producer.
  always_comb begin
    fwd_a_s = {SEL_W{1'b0}};
    fwd_b_s = {SEL_W{1'b0}};
`ifdef PIPE_FWD_EN
    for (int k = NPOST; k >= 2; k--) begin
      if (!ld_q[k] || (k >= LOAD_RDY)) begin
        if (match_f(vld_q[k], wen_q[k], wreg_q[k], ex_rs_q, ex_urs_q)) begin
          fwd_a_s = SEL_W'(k);
        end else begin
          fwd_a_s = fwd_a_s;
        end
        if (match_f(vld_q[k], wen_q[k], wreg_q[k], ex_rt_q, ex_urt_q)) begin
          fwd_b_s = SEL_W'(k);
        end else begin
          fwd_b_s = fwd_b_s;
        end
      end else begin
        fwd_a_s = fwd_a_s;
        fwd_b_s = fwd_b_s;
      end
    end
`endif
  end

  // Tag advance; a bubble carries no write, load or source-use bits.
  always_comb begin
    vld_d[1]  = take_s;
    wen_d[1]  = id_wr_en & take_s;
    ld_d[1]   = id_is_load & take_s;
    wreg_d[1] = id_wr_reg;
    ex_rs_d   = id_rs;
    ex_rt_d   = id_rt;
    ex_urs_d  = id_use_rs & take_s;
    ex_urt_d  = id_use_rt & take_s;
    for (int k = 2; k <= NPOST; k++) begin
      // Entries younger than the resolving stage are squashed as they advance.
      vld_d[k]  = vld_q[k-1] & ~(flush_s & ((k - 1) < RESOLVE));
      wen_d[k]  = wen_q[k-1];
      ld_d[k]   = ld_q[k-1];
      wreg_d[k] = wreg_q[k-1];
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_s && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= {NPOST{1'b0}};
      wen_q       <= {NPOST{1'b0}};
      ld_q        <= {NPOST{1'b0}};
      ex_rs_q     <= {RA_W{1'b0}};
      ex_rt_q     <= {RA_W{1'b0}};
      ex_urs_q    <= 1'b0;
      ex_urt_q    <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
      for (int k = 1; k <= NPOST; k++) begin
        wreg_q[k] <= {RA_W{1'b0}};
      end
    end else begin
      vld_q       <= vld_d;
      wen_q       <= wen_d;
      ld_q        <= ld_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_urs_q    <= ex_urs_d;
      ex_urt_q    <= ex_urt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int k = 1; k <= NPOST; k++) begin
        wreg_q[k] <= wreg_d[k];
      end
    end
  end

`ifndef PIPE_FWD_EN
  // Without forwarding the EX sources, load flags and oldest entry are not consulted.
  logic unused_s;
  assign unused_s = ^{vld_q[NPOST], wen_q[NPOST], wreg_q[NPOST], ld_q,
                      ex_rs_q, ex_rt_q, ex_urs_q, ex_urt_q};
`endif

  assign stall     = stall_s;
  assign flush     = flush_s;
  assign fwd_a_sel = fwd_a_s;
  assign fwd_b_sel = fwd_b_s;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
